// File: rtl/axi4lite_apb_bridge_pkg.sv
// Shared types for the AXI4-Lite to APB command bridge: FSM states and AXI response codes.
package axi_apb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_APB  = 3'd1,
        WR_RESP = 3'd2,
        RD_APB  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4lite_apb_bridge_if.sv
// AXI4-Lite slave channels plus the APB master command interface seen by the bridge.
interface axi4lite_apb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    logic                  transfer;
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] apb_waddr;
    logic [ADDR_WIDTH-1:0] apb_raddr;
    logic [DATA_WIDTH-1:0] apb_wdata;
    logic [STRB_WIDTH-1:0] apb_wstrb;
    logic [DATA_WIDTH-1:0] apb_rdata;
    logic                  apb_done;
    logic                  apb_error;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        output transfer, read, write, apb_waddr, apb_raddr, apb_wdata, apb_wstrb,
        input  apb_rdata, apb_done, apb_error
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        input  transfer, read, write, apb_waddr, apb_raddr, apb_wdata, apb_wstrb,
        output apb_rdata, apb_done, apb_error
    );

endinterface

// File: rtl/axi4lite_wr_collect.sv
// Holds the AW and W beats of one AXI write until both halves are present.
module axi4lite_wr_collect
    import axi_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    accept_en,
    input  logic                    clr,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    awready,
    output logic                    wready,
    output logic                    aw_fire,
    output logic                    w_fire,
    output logic                    aw_held,
    output logic                    w_held,
    output logic [ADDR_WIDTH-1:0]   waddr_q,
    output logic [DATA_WIDTH-1:0]   wdata_q,
    output logic [DATA_WIDTH/8-1:0] wstrb_q
);

    logic                    aw_held_r;
    logic                    w_held_r;
    logic [ADDR_WIDTH-1:0]   waddr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH/8-1:0] wstrb_r;

    assign awready = accept_en & ~aw_held_r;
    assign wready  = accept_en & ~w_held_r;
    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign aw_held = aw_held_r;
    assign w_held  = w_held_r;
    assign waddr_q = waddr_r;
    assign wdata_q = wdata_r;
    assign wstrb_q = wstrb_r;

    // Capture each beat independently; both flags drop together when the write completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            waddr_r   <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= {DATA_WIDTH{1'b0}};
            wstrb_r   <= {(DATA_WIDTH/8){1'b0}};
        end else begin
            if (clr) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
            end else begin
                aw_held_r <= aw_held_r | aw_fire;
                w_held_r  <= w_held_r | w_fire;
            end
            if (aw_fire) begin
                waddr_r <= awaddr;
            end
            if (w_fire) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
        end
    end

endmodule

// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB command bridge, one transaction outstanding at a time.
// Optional APB wait timeout enabled by defining AXI4LITE_APB_BRIDGE_TIMEOUT_EN.
module axi4lite_apb_bridge
    import axi_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                   ACLK,
    input logic                   ARESETn,
    axi4lite_apb_bridge_if.slave  bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                state_r;
    state_t                next_state_s;
    logic                  run_r;
    logic                  prio_r;
    logic [ADDR_WIDTH-1:0] araddr_r;
    logic                  transfer_r;
    logic                  read_r;
    logic                  write_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic                  rvalid_r;
    logic [1:0]            rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    logic                  idle_s;
    logic                  awready_s;
    logic                  wready_s;
    logic                  aw_fire_s;
    logic                  w_fire_s;
    logic                  aw_held_s;
    logic                  w_held_s;
    logic [ADDR_WIDTH-1:0] waddr_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [STRB_WIDTH-1:0] wstrb_s;
    logic                  wr_ready_s;
    logic                  ar_open_s;
    logic                  tie_s;
    logic                  arready_s;
    logic                  rd_ready_s;
    logic                  apb_phase_s;
    logic                  timeout_s;
    logic                  done_s;
    logic                  err_s;
    logic                  clr_s;

    axi4lite_wr_collect #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_collect (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .accept_en (idle_s),
        .clr       (clr_s),
        .awaddr    (bus.AWADDR),
        .awvalid   (bus.AWVALID),
        .wdata     (bus.WDATA),
        .wstrb     (bus.WSTRB),
        .wvalid    (bus.WVALID),
        .awready   (awready_s),
        .wready    (wready_s),
        .aw_fire   (aw_fire_s),
        .w_fire    (w_fire_s),
        .aw_held   (aw_held_s),
        .w_held    (w_held_s),
        .waddr_q   (waddr_s),
        .wdata_q   (wdata_s),
        .wstrb_q   (wstrb_s)
    );

    // run_r keeps every READY low during reset and the first cycle after release
    assign idle_s      = run_r & (state_r == IDLE);
    assign wr_ready_s  = (aw_held_s | aw_fire_s) & (w_held_s | w_fire_s);
    assign ar_open_s   = idle_s & ~aw_held_s & ~w_held_s;
    assign tie_s       = ar_open_s & bus.ARVALID & wr_ready_s;
    assign arready_s   = ar_open_s & ~(tie_s & prio_r);
    assign rd_ready_s  = bus.ARVALID & arready_s;
    assign apb_phase_s = (state_r == WR_APB) | (state_r == RD_APB);
    assign done_s      = apb_phase_s & (bus.apb_done | timeout_s);
    assign err_s       = bus.apb_done ? bus.apb_error : 1'b1;
    assign clr_s       = (state_r == WR_APB) & done_s;

`ifdef AXI4LITE_APB_BRIDGE_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] to_cnt_r;

    // Counts cycles spent waiting on the APB master; restarts on every state entry.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((next_state_s != state_r) || !apb_phase_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    assign timeout_s = apb_phase_s & (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state decode; on an AR/write tie prio_r low lets the read through.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (rd_ready_s) begin
                    next_state_s = RD_APB;
                end else if (idle_s && wr_ready_s) begin
                    next_state_s = WR_APB;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WR_APB:  next_state_s = done_s ? WR_RESP : WR_APB;
            WR_RESP: next_state_s = bus.BREADY ? IDLE : WR_RESP;
            RD_APB:  next_state_s = done_s ? RD_RESP : RD_APB;
            RD_RESP: next_state_s = bus.RREADY ? IDLE : RD_RESP;
            default: next_state_s = IDLE;
        endcase
    end

    // State, tie-break priority, read address and the APB command strobes.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r    <= IDLE;
            run_r      <= 1'b0;
            prio_r     <= 1'b0;
            araddr_r   <= {ADDR_WIDTH{1'b0}};
            transfer_r <= 1'b0;
            write_r    <= 1'b0;
            read_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            run_r      <= 1'b1;
            prio_r     <= tie_s ? ~prio_r : prio_r;
            araddr_r   <= rd_ready_s ? bus.ARADDR : araddr_r;
            transfer_r <= (next_state_s == WR_APB) | (next_state_s == RD_APB);
            write_r    <= (next_state_s == WR_APB);
            read_r     <= (next_state_s == RD_APB);
        end
    end

    // B and R response registers; payload is frozen while VALID waits for READY.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            if (clr_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= resp_code(err_s);
            end else if ((state_r == WR_RESP) && bus.BREADY) begin
                bvalid_r <= 1'b0;
            end else begin
                bvalid_r <= bvalid_r;
            end
            if ((state_r == RD_APB) && done_s) begin
                rvalid_r <= 1'b1;
                rresp_r  <= resp_code(err_s);
                rdata_r  <= bus.apb_done ? bus.apb_rdata : {DATA_WIDTH{1'b0}};
            end else if ((state_r == RD_RESP) && bus.RREADY) begin
                rvalid_r <= 1'b0;
            end else begin
                rvalid_r <= rvalid_r;
            end
        end
    end

    assign bus.AWREADY   = awready_s;
    assign bus.WREADY    = wready_s;
    assign bus.ARREADY   = arready_s;
    assign bus.BVALID    = bvalid_r;
    assign bus.BRESP     = bresp_r;
    assign bus.RVALID    = rvalid_r;
    assign bus.RRESP     = rresp_r;
    assign bus.RDATA     = rdata_r;
    assign bus.transfer  = transfer_r;
    assign bus.write     = write_r;
    assign bus.read      = read_r;
    assign bus.apb_waddr = waddr_s;
    assign bus.apb_wdata = wdata_s;
    assign bus.apb_wstrb = wstrb_s;
    assign bus.apb_raddr = araddr_r;

endmodule

// File: tb/tb_axi4lite_apb_bridge.sv
// Directed self-checking bench for axi4lite_apb_bridge with a small APB completion responder.
module tb_axi4lite_apb_bridge;

    localparam int TO = 16;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    int          apb_lat;
    bit          resp_en;
    bit          err_v;
    logic [31:0] rdata_v;
    bit          served_q[$];

    axi4lite_apb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4lite_apb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // APB responder: pulses apb_done apb_lat cycles after transfer is seen; logs served type.
    initial begin
        int lat_cnt;
        lat_cnt       = 0;
        bus.apb_done  = 1'b0;
        bus.apb_error = 1'b0;
        bus.apb_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.apb_rdata = rdata_v;
            if (bus.apb_done) begin
                bus.apb_done  = 1'b0;
                bus.apb_error = 1'b0;
                lat_cnt       = 0;
            end else if (resp_en && bus.transfer) begin
                lat_cnt++;
                if (lat_cnt >= apb_lat) begin
                    bus.apb_done  = 1'b1;
                    bus.apb_error = err_v;
                    served_q.push_back(bus.write);
                    lat_cnt       = 0;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Presents AW/W and/or AR together and drops each valid after its handshake.
    task automatic axi_issue(input bit do_w, input bit do_r, input logic [31:0] waddr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic [31:0] raddr);
        bit aw_hs, w_hs, ar_hs;
        @(posedge clk);
        #1;
        bus.AWADDR  = waddr;
        bus.WDATA   = wdata;
        bus.WSTRB   = wstrb;
        bus.ARADDR  = raddr;
        bus.AWVALID = do_w;
        bus.WVALID  = do_w;
        bus.ARVALID = do_r;
        for (int i = 0; i < 100 && (bus.AWVALID || bus.WVALID || bus.ARVALID); i++) begin
            @(negedge clk);
            aw_hs = bus.AWVALID & bus.AWREADY;
            w_hs  = bus.WVALID & bus.WREADY;
            ar_hs = bus.ARVALID & bus.ARREADY;
            @(posedge clk);
            #1;
            if (aw_hs) bus.AWVALID = 1'b0;
            if (w_hs)  bus.WVALID  = 1'b0;
            if (ar_hs) bus.ARVALID = 1'b0;
        end
        vectors++;
        if (bus.AWVALID || bus.WVALID || bus.ARVALID) begin
            miscompares++;
            $display("FAIL issue_handshake: valids still pending aw=%b w=%b ar=%b, required all accepted",
                     bus.AWVALID, bus.WVALID, bus.ARVALID);
            bus.AWVALID = 1'b0;
            bus.WVALID  = 1'b0;
            bus.ARVALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
             bus.transfer, bus.read, bus.write} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                      bus.transfer, bus.read, bus.write});
        end
        vectors++;
        if ({bus.BRESP, bus.RRESP, bus.RDATA, bus.apb_waddr, bus.apb_raddr, bus.apb_wdata, bus.apb_wstrb} !== 136'h0) begin
            miscompares++;
            $display("FAIL reset_data: got nonzero payload rdata=%h waddr=%h raddr=%h wdata=%h, required 0",
                     bus.RDATA, bus.apb_waddr, bus.apb_raddr, bus.apb_wdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.transfer} !== 4'b1110) begin
            miscompares++;
            $display("FAIL post_reset_ready: got %b required 1110",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.transfer});
        end
    endtask

    task automatic test_write_aw_first();
        apb_lat = 2;
        @(posedge clk);
        #1;
        bus.AWADDR  = 32'h0000_0010;
        bus.AWVALID = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.AWREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_awready: got %b required 1", bus.AWREADY);
        end
        @(posedge clk);
        #1;
        bus.AWVALID = 1'b0;
        bus.AWADDR  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.transfer} !== 4'b0100) begin
            miscompares++;
            $display("FAIL wr_aw_held: got %b required 0100",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.transfer});
        end
        @(posedge clk);
        #1;
        bus.WDATA  = 32'hDEAD_BEEF;
        bus.WSTRB  = 4'hF;
        bus.WVALID = 1'b1;
        @(posedge clk);
        #1;
        bus.WVALID = 1'b0;
        bus.WDATA  = 32'h0;
        @(negedge clk);
        vectors++;
        if ({bus.transfer, bus.write, bus.read} !== 3'b110) begin
            miscompares++;
            $display("FAIL wr_cmd: got transfer/write/read=%b required 110",
                     {bus.transfer, bus.write, bus.read});
        end
        for (int i = 0; i < 20 && !bus.BVALID; i++) begin
            if (bus.transfer) begin
                vectors++;
                if ({bus.apb_waddr, bus.apb_wdata, bus.apb_wstrb} !== {32'h0000_0010, 32'hDEAD_BEEF, 4'hF}) begin
                    miscompares++;
                    $display("FAIL wr_payload: got addr=%h data=%h strb=%h required 00000010 deadbeef f",
                             bus.apb_waddr, bus.apb_wdata, bus.apb_wstrb);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if ({bus.BVALID, bus.BRESP, bus.transfer} !== 4'b1000) begin
            miscompares++;
            $display("FAIL wr_bresp: got bvalid/bresp/transfer=%b required 1000",
                     {bus.BVALID, bus.BRESP, bus.transfer});
        end
        @(negedge clk);
        vectors++;
        if (bus.BVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_bclear: got %b required 0", bus.BVALID);
        end
    endtask

    task automatic test_read_error();
        apb_lat = 1;
        rdata_v = 32'h1234_5678;
        err_v   = 1'b1;
        axi_issue(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_0020);
        @(negedge clk);
        vectors++;
        if ({bus.transfer, bus.read, bus.write, bus.apb_raddr} !== {3'b110, 32'h0000_0020}) begin
            miscompares++;
            $display("FAIL rd_cmd: got t/r/w=%b raddr=%h required 110 00000020",
                     {bus.transfer, bus.read, bus.write}, bus.apb_raddr);
        end
        for (int i = 0; i < 20 && !bus.RVALID; i++) @(negedge clk);
        vectors++;
        if ({bus.RVALID, bus.RRESP, bus.RDATA} !== {1'b1, 2'b10, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL rd_err_resp: got rvalid=%b rresp=%b rdata=%h required 1 10 12345678",
                     bus.RVALID, bus.RRESP, bus.RDATA);
        end
        err_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        apb_lat = 1;
        rdata_v = 32'h0BAD_CAFE;
        served_q.delete();
        for (int t = 0; t < 2; t++) begin
            axi_issue(1'b1, 1'b1, 32'h30 + 32'(t), 32'h1111_1111, 4'hF, 32'h40 + 32'(t));
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                vectors++;
                if (bus.read && bus.write) begin
                    miscompares++;
                    $display("FAIL tie_overlap: got read=1 write=1 required one-hot");
                end
                if (served_q.size() == 2 * (t + 1) && !bus.transfer && !bus.BVALID && !bus.RVALID) break;
            end
        end
        vectors++;
        if (served_q.size() != 4) begin
            miscompares++;
            $display("FAIL tie_count: got %0d served required 4", served_q.size());
        end else begin
            vectors++;
            if ({served_q[0], served_q[1], served_q[2], served_q[3]} !== 4'b0110) begin
                miscompares++;
                $display("FAIL tie_order: got %b (1=write) required 0110",
                         {served_q[0], served_q[1], served_q[2], served_q[3]});
            end
        end
    endtask

    task automatic test_backpressure();
        apb_lat    = 1;
        err_v      = 1'b1;
        bus.BREADY = 1'b0;
        axi_issue(1'b1, 1'b0, 32'h80, 32'hCAFE_F00D, 4'h3, 32'h0);
        for (int i = 0; i < 20 && !bus.BVALID; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, bus.ARREADY} !== 6'b110000) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: got bvalid/bresp/awr/wr/arr=%b required 110000",
                         i, {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, bus.ARREADY});
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.BREADY = 1'b1;
        err_v      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.BVALID, bus.AWREADY, bus.ARREADY} !== 3'b011) begin
            miscompares++;
            $display("FAIL bp_release: got bvalid/awr/arr=%b required 011",
                     {bus.BVALID, bus.AWREADY, bus.ARREADY});
        end
    endtask

    task automatic test_reset_mid();
        apb_lat = 1;
        resp_en = 1'b0;
        axi_issue(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h50);
        @(negedge clk);
        vectors++;
        if ({bus.transfer, bus.read} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_mid_pre: got transfer/read=%b required 11", {bus.transfer, bus.read});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.transfer, bus.read, bus.RVALID, bus.ARREADY} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_mid_clear: got transfer/read/rvalid/arready=%b required 0000",
                     {bus.transfer, bus.read, bus.RVALID, bus.ARREADY});
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        resp_en = 1'b1;
        rdata_v = 32'hA5A5_0F0F;
        axi_issue(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h60);
        @(negedge clk);
        vectors++;
        if (bus.apb_raddr !== 32'h60) begin
            miscompares++;
            $display("FAIL rst_after_raddr: got %h required 00000060", bus.apb_raddr);
        end
        for (int i = 0; i < 20 && !bus.RVALID; i++) @(negedge clk);
        vectors++;
        if ({bus.RVALID, bus.RRESP, bus.RDATA} !== {1'b1, 2'b00, 32'hA5A5_0F0F}) begin
            miscompares++;
            $display("FAIL rst_after_read: got rvalid=%b rresp=%b rdata=%h required 1 00 a5a50f0f",
                     bus.RVALID, bus.RRESP, bus.RDATA);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        resp_en = 1'b0;
        rdata_v = 32'hFFFF_FFFF;
        n       = 0;
        axi_issue(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h70);
        for (int i = 0; i < TO + 20; i++) begin
            @(negedge clk);
            if (!bus.transfer) break;
            n++;
        end
        vectors++;
        if (n != TO) begin
            miscompares++;
            $display("FAIL to_cycles: got %0d transfer cycles required %0d", n, TO);
        end
        vectors++;
        if ({bus.transfer, bus.RVALID, bus.RRESP, bus.RDATA} !== {1'b0, 1'b1, 2'b10, 32'h0}) begin
            miscompares++;
            $display("FAIL to_resp: got transfer=%b rvalid=%b rresp=%b rdata=%h required 0 1 10 00000000",
                     bus.transfer, bus.RVALID, bus.RRESP, bus.RDATA);
        end
        resp_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        apb_lat      = 1;
        resp_en      = 1'b1;
        err_v        = 1'b0;
        rdata_v      = 32'h0;
        rst_n        = 1'b0;
        bus.AWADDR   = 32'h0;
        bus.AWVALID  = 1'b0;
        bus.WDATA    = 32'h0;
        bus.WSTRB    = 4'h0;
        bus.WVALID   = 1'b0;
        bus.BREADY   = 1'b1;
        bus.ARADDR   = 32'h0;
        bus.ARVALID  = 1'b0;
        bus.RREADY   = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_write_aw_first();
        test_read_error();
        test_tie();
        test_backpressure();
        test_reset_mid();
`ifdef AXI4LITE_APB_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4lite_apb_bridge.md
Name: axi4lite_apb_bridge

Overview:
- AXI4-Lite slave front-end that converts single-beat AXI read and write transactions into the APB master's command interface: transfer, read, write, WSTRB, apb_waddr, apb_raddr, apb_wdata and apb_rdata.
- Sits directly upstream of the APB master/mux/slave subsystem and returns AXI R and B responses once the APB access completes.
- Exactly one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, AXI/APB address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, APB wait limit in cycles; used only with the optional feature

Ports:
- ACLK  in  1  single clock; the APB side runs on the same clock
- ARESETn  in  1  asynchronous active-low reset
- AWADDR  in  ADDR_WIDTH  write address
- AWVALID  in  1 / AWREADY  out  1  write-address handshake
- WDATA  in  DATA_WIDTH / WSTRB  in  DATA_WIDTH/8  write data and byte strobes
- WVALID  in  1 / WREADY  out  1  write-data handshake
- BRESP  out  2 / BVALID  out  1 / BREADY  in  1  write response channel
- ARADDR  in  ADDR_WIDTH / ARVALID  in  1 / ARREADY  out  1  read-address channel
- RDATA  out  DATA_WIDTH / RRESP  out  2 / RVALID  out  1 / RREADY  in  1  read data channel
- transfer  out  1  APB command valid
- read, write  out  1 each  command type; exactly one is high while transfer is high
- apb_waddr, apb_raddr  out  ADDR_WIDTH  command addresses
- apb_wdata  out  DATA_WIDTH  write data
- apb_wstrb  out  DATA_WIDTH/8  strobes, connected to the APB master's WSTRB
- apb_rdata  in  DATA_WIDTH  read data returned by the APB master
- apb_done  in  1  one-cycle completion pulse from the APB master
- apb_error  in  1  PSLVERR qualifier, valid while apb_done is high

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - aw_held, w_held and the priority bit are cleared.
- Address and data capture:
  - AWREADY = ~aw_held while not in a WR/RD or response state; same rule for WREADY with ~w_held.
  - AW and W may arrive in the same cycle or in either order.
  - Each accepted beat is registered and its held flag is set.
- ARREADY is high only in IDLE when no write is partially held (aw_held|w_held == 0).
- State machine: IDLE -> WR_APB -> WR_RESP -> IDLE, and IDLE -> RD_APB -> RD_RESP -> IDLE.
- IDLE arbitration:
  - A write is ready when aw_held & w_held; a read is ready when ARVALID & ARREADY.
  - If both are ready in the same cycle, the priority bit chooses, then toggles, so ties alternate with the first tie going to read.
  - Otherwise the ready transaction goes.
- WR_APB:
  - transfer=1, write=1, and apb_waddr/apb_wdata/apb_wstrb are driven from the registers, held stable.
  - On apb_done: drop transfer/write the next cycle, set BRESP = apb_error ? 2'b10 : 2'b00, set BVALID=1, clear both held flags, go to WR_RESP.
- WR_RESP: hold BVALID until BREADY is high, then go to IDLE.
- RD_APB:
  - transfer=1, read=1, apb_raddr is driven.
  - On apb_done: register RDATA=apb_rdata and RRESP as for writes, set RVALID=1, go to RD_RESP.
- RD_RESP: hold RVALID until RREADY is high, then go to IDLE.
- Latency: the minimum is 1 cycle from AW/W capture to transfer, plus APB latency, plus 1 cycle to B/R valid.
- apb_done while not in WR_APB or RD_APB is ignored.
- Response channels: BVALID and RVALID never drop without the matching READY, and their payloads are stable while valid.
- Reset mid-operation clears everything immediately, including an active transfer. Any in-flight AXI transaction is lost.

Optional Feature:
- Macro: AXI4LITE_APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter runs in WR_APB and RD_APB.
  - If TIMEOUT_CYCLES elapse without apb_done, transfer is dropped and the response is issued with SLVERR (2'b10); RDATA=0 for reads.
  - The counter clears on every state entry.
- Undefined: no counter; the bridge waits on apb_done indefinitely.

Decomposition:
- Package axi_apb_pkg holds:
  - the state enum (IDLE, WR_APB, WR_RESP, RD_APB, RD_RESP);
  - the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- One natural sub-module, axi4lite_wr_collect: the AW/W holding registers and held flags.

Test Plan:
- Write, AW then W 3 cycles later:
  - Stimulus: AWADDR=0x0000_0010, WDATA=0xDEADBEEF, WSTRB=4'hF, apb_done 2 cycles after transfer.
  - Required: apb_waddr=0x10 and apb_wdata=0xDEADBEEF while transfer=1; BVALID=1 with BRESP=00.
- Read with error:
  - Stimulus: ARADDR=0x20, apb_rdata=0x1234_5678 and apb_error=1 on apb_done.
  - Required: RDATA=0x12345678, RRESP=10.
- Simultaneous AW+W+AR in IDLE, twice:
  - Required: the first tie serves the read, the second tie serves the write; never two transfers overlap.
- Backpressure:
  - Stimulus: BREADY=0 for 5 cycles after BVALID.
  - Required: BVALID and BRESP held stable; AWREADY, WREADY and ARREADY stay 0 until BREADY.
- Reset:
  - Stimulus: ARESETn asserted in RD_APB.
  - Required: transfer, RVALID and ARREADY read 0 in the same cycle; the next read completes normally after release.
- Timeout (macro defined):
  - Stimulus: apb_done never arrives.
  - Required: after TIMEOUT_CYCLES, transfer=0 and RVALID=1 with RRESP=10.
